// File: rtl/lift_request_latch.sv
// rtl/lift_request_latch.sv - synchronized, edge-latched lift hall/car requests
// Optional debounce filter enabled by defining LIFT_REQ_DEBOUNCE_EN.
module lift_request_latch #(
    parameter int FLOORS          = 7,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [FLOORS-1:0] up_press,
    input  logic [FLOORS-1:0] down_press,
    input  logic [FLOORS-1:0] inside_press,
    input  logic [FLOORS-1:0] reset_up,
    input  logic [FLOORS-1:0] reset_down,
    input  logic [FLOORS-1:0] reset_inside_button,
    output logic [FLOORS-1:0] up_button,
    output logic [FLOORS-1:0] down_button,
    output logic [FLOORS-1:0] inside_button,
    output logic              any_request,
    output logic [4:0]        pending_count
);
    localparam int N = 3 * FLOORS;
`ifdef LIFT_REQ_DEBOUNCE_EN
    localparam bit DEBOUNCE_EN = 1'b1;
`else
    localparam bit DEBOUNCE_EN = 1'b0;
`endif
    // A button held across reset is fully accepted by this edge; rises up to it are not real presses.
    localparam int WARM_EDGES = 3 + (DEBOUNCE_EN ? DEBOUNCE_CYCLES : 0);
    // Flat vectors hold up, then down, then inside; top-floor up and ground-floor down do not exist.
    localparam logic [N-1:0] VALID_MASK = ~((N'(1) << (FLOORS - 1)) | (N'(1) << FLOORS));

    logic [N-1:0] press_all;
    logic [N-1:0] clr_all;
    logic [N-1:0] accepted;
    logic [N-1:0] rise;
    logic [N-1:0] sync1_q, sync1_d;
    logic [N-1:0] sync2_q, sync2_d;
    logic [N-1:0] prev_q, prev_d;
    logic [N-1:0] req_q, req_d;
    logic [4:0]   warm_q, warm_d;
    logic         warm_open;

    assign press_all = {inside_press, down_press, up_press} & VALID_MASK;
    assign clr_all   = {reset_inside_button, reset_down, reset_up};

`ifdef LIFT_REQ_DEBOUNCE_EN
    logic [N-1:0]      acc_q, acc_d;
    logic [N-1:0][3:0] cnt_q, cnt_d;

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        for (int i = 0; i < N; i++) begin
            if (sync2_q[i] == acc_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] + 4'd1 == 4'(DEBOUNCE_CYCLES)) begin
                acc_d[i] = sync2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    assign accepted = acc_q;
`else
    assign accepted = sync2_q;
`endif

    always_comb begin
        sync1_d   = press_all;
        sync2_d   = sync1_q;
        prev_d    = accepted;
        warm_open = (warm_q == 5'(WARM_EDGES));
        warm_d    = warm_open ? warm_q : warm_q + 5'd1;
        rise      = accepted & ~prev_q & {N{warm_open}};
        // Clear beats a same-edge rise; the rise is a one-cycle event, so it is lost for good.
        if (start) begin
            req_d = '0;
        end else begin
            req_d = (req_q | rise) & ~clr_all & VALID_MASK;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            req_q   <= '0;
            warm_q  <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            req_q   <= req_d;
            warm_q  <= warm_d;
        end
    end

    assign up_button     = req_q[FLOORS-1:0];
    assign down_button   = req_q[2*FLOORS-1:FLOORS];
    assign inside_button = req_q[3*FLOORS-1:2*FLOORS];
    assign any_request   = |req_q;

    always_comb begin
        pending_count = '0;
        for (int i = 0; i < N; i++) begin
            pending_count = pending_count + 5'(req_q[i]);
        end
    end
endmodule

// File: tb/tb_lift_request_latch.sv
// tb/tb_lift_request_latch.sv - randomized and directed bench for lift_request_latch
// Honours LIFT_REQ_DEBOUNCE_EN to select expected latencies.
module tb_lift_request_latch;
    localparam int FLOORS          = 7;
    localparam int DEBOUNCE_CYCLES = 4;
    localparam int N               = 3 * FLOORS;
`ifdef LIFT_REQ_DEBOUNCE_EN
    localparam int DEB     = DEBOUNCE_CYCLES;
    localparam int LAG     = 3;
    localparam int EXP_LAT = 3 + DEBOUNCE_CYCLES;
`else
    localparam int DEB     = 1;
    localparam int LAG     = 2;
    localparam int EXP_LAT = 3;
`endif
    localparam int WARM = DEB + LAG;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic [N-1:0]      press_v = '0;
    logic [N-1:0]      clr_v = '0;
    logic [FLOORS-1:0] up_button, down_button, inside_button;
    logic              any_request;
    logic [4:0]        pending_count;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model on the raw-sample timeline: a level is accepted after DEB
    // consecutive differing samples; an accepted rise lands LAG edges later.
    bit       m_acc[N];
    int       m_run[N];
    bit [3:0] m_hist[N];
    bit       m_req[N];
    int       m_edge;

    lift_request_latch #(.FLOORS(FLOORS), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .start               (start),
        .up_press            (press_v[FLOORS-1:0]),
        .down_press          (press_v[2*FLOORS-1:FLOORS]),
        .inside_press        (press_v[3*FLOORS-1:2*FLOORS]),
        .reset_up            (clr_v[FLOORS-1:0]),
        .reset_down          (clr_v[2*FLOORS-1:FLOORS]),
        .reset_inside_button (clr_v[3*FLOORS-1:2*FLOORS]),
        .up_button           (up_button),
        .down_button         (down_button),
        .inside_button       (inside_button),
        .any_request         (any_request),
        .pending_count       (pending_count)
    );

    always #5 clk = ~clk;

    function automatic int up_i(input int f);
        return f;
    endfunction
    function automatic int dn_i(input int f);
        return FLOORS + f;
    endfunction
    function automatic int in_i(input int f);
        return 2 * FLOORS + f;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < N; b++) begin
            m_acc[b]  = 1'b0;
            m_run[b]  = 0;
            m_hist[b] = '0;
            m_req[b]  = 1'b0;
        end
        m_edge = 0;
    endtask

    task automatic model_edge();
        bit rise_now;
        bit fire;
        m_edge++;
        for (int b = 0; b < N; b++) begin
            rise_now = 1'b0;
            if (press_v[b] != m_acc[b]) begin
                m_run[b]++;
                if (m_run[b] >= DEB) begin
                    m_acc[b] = press_v[b];
                    m_run[b] = 0;
                    rise_now = press_v[b];
                end
            end else begin
                m_run[b] = 0;
            end
            m_hist[b] = {m_hist[b][2:0], rise_now};
            fire = m_hist[b][LAG] && (m_edge > WARM) && (b != FLOORS - 1) && (b != FLOORS);
            if (start || clr_v[b]) m_req[b] = 1'b0;
            else if (fire) m_req[b] = 1'b1;
        end
    endtask

    task automatic compare_all(input string tag);
        logic [N-1:0] e;
        int cnt;
        cnt = 0;
        for (int b = 0; b < N; b++) begin
            e[b] = m_req[b];
            cnt += int'(m_req[b]);
        end
        check({tag, ":up"}, up_button, e[FLOORS-1:0]);
        check({tag, ":down"}, down_button, e[2*FLOORS-1:FLOORS]);
        check({tag, ":inside"}, inside_button, e[3*FLOORS-1:2*FLOORS]);
        check({tag, ":pending"}, pending_count, cnt);
        check({tag, ":any"}, any_request, (cnt != 0) ? 1 : 0);
    endtask

    task automatic step();
        @(posedge clk);
        if (reset_n) model_edge();
        @(negedge clk);
        compare_all("cyc");
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int lat;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all("rst");
        check("rst_pending", pending_count, 0);
        reset_n = 1'b1;
        idle(WARM + 2);

        // Held press: latency, count and any_request.
        press_v[up_i(2)] = 1'b1;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (up_button[2] && lat == 0) lat = i;
        end
        check("lat_up2", lat, EXP_LAT);
        check("pend_up2", pending_count, 1);
        check("any_up2", any_request, 1);
        clr_v[up_i(2)] = 1'b1;
        step();
        clr_v = '0;
        press_v = '0;
        idle(DEB + 3);

`ifdef LIFT_REQ_DEBOUNCE_EN
        // Glitch shorter than the debounce window.
        press_v[up_i(2)] = 1'b1;
        idle(3);
        press_v[up_i(2)] = 1'b0;
        idle(12);
        check("glitch_up2", up_button[2], 0);
`endif

        // Set and clear on the same edge: clear wins, no re-latch while held.
        press_v[dn_i(3)] = 1'b1;
        idle(EXP_LAT - 1);
        clr_v[dn_i(3)] = 1'b1;
        step();
        check("same_edge_dn3", down_button[3], 0);
        clr_v = '0;
        idle(5);
        check("no_relatch_dn3", down_button[3], 0);
        press_v = '0;
        idle(DEB + 3);

        // Clear while held, then release and re-press.
        press_v[in_i(4)] = 1'b1;
        idle(EXP_LAT + 1);
        check("in4_set", inside_button[4], 1);
        clr_v[in_i(4)] = 1'b1;
        step();
        check("in4_clr", inside_button[4], 0);
        clr_v = '0;
        idle(10);
        check("in4_held", inside_button[4], 0);
        press_v[in_i(4)] = 1'b0;
        idle(DEB + 3);
        press_v[in_i(4)] = 1'b1;
        idle(EXP_LAT);
        check("in4_repress", inside_button[4], 1);
        clr_v[in_i(4)] = 1'b1;
        press_v = '0;
        step();
        clr_v = '0;
        idle(DEB + 3);

        // Five presses including the two nonexistent directions.
        press_v[dn_i(0)] = 1'b1;
        press_v[up_i(6)] = 1'b1;
        press_v[up_i(1)] = 1'b1;
        press_v[dn_i(5)] = 1'b1;
        press_v[in_i(2)] = 1'b1;
        idle(EXP_LAT + 1);
        check("pend_five", pending_count, 3);
        check("dn0_zero", down_button[0], 0);
        check("up6_zero", up_button[6], 0);

        // Start clears and holds clear; held buttons do not re-latch.
        press_v[in_i(0)] = 1'b1;
        idle(EXP_LAT + 1);
        check("pend_four", pending_count, 4);
        start = 1'b1;
        step();
        check("start_pend", pending_count, 0);
        check("start_any", any_request, 0);
        idle(3);
        start = 1'b0;
        idle(10);
        check("start_held", pending_count, 0);
        press_v = '0;
        idle(DEB + 3);

        // Asynchronous reset mid-acceptance with requests latched.
        press_v[up_i(1)] = 1'b1;
        press_v[in_i(3)] = 1'b1;
        idle(EXP_LAT + 1);
        check("pend_two", pending_count, 2);
        press_v[up_i(2)] = 1'b1;
        idle(2);
        reset_n = 1'b0;
        #1;
        check("arst_pend", pending_count, 0);
        check("arst_any", any_request, 0);
        check("arst_up", up_button, 0);
        check("arst_inside", inside_button, 0);
        model_reset();
        idle(3);
        reset_n = 1'b1;
        idle(WARM + 10);
        check("rel_held", pending_count, 0);
        press_v = '0;
        idle(DEB + 3);

        // Randomized traffic against the model.
        for (int c = 0; c < 800; c++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 11) == 0) press_v[b] = ~press_v[b];
                clr_v[b] = ($urandom_range(0, 39) == 0);
            end
            start = ($urandom_range(0, 149) == 0);
            if (c == 400) begin
                reset_n = 1'b0;
                #1;
                model_reset();
                compare_all("rnd_arst");
            end
            if (c == 403) reset_n = 1'b1;
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
